// File: rtl/benes_select_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : benes_select_loader_pkg
//  Brief    : Shared types and geometry helpers for the Benes select loader.
//  Revision : 1.0 - initial release
// ============================================================================
package benes_select_loader_pkg;

    // Loader control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_ARMED = 2'b10,
        ST_ERROR = 2'b11
    } state_e;

    // Sticky error causes reported on O_ERR_CODE
    typedef enum logic [1:0] {
        ERR_NONE       = 2'b00,
        ERR_EARLY_LAST = 2'b01,
        ERR_NO_LAST    = 2'b10,
        ERR_PARITY     = 2'b11
    } err_code_e;

    // Switch stages in a Benes network of port_num ports
    function automatic int stage_num(input int port_num);
        return 2 * $clog2(port_num) - 1;
    endfunction

    // Beats in a complete configuration (both networks)
    function automatic int beat_num(input int port_num);
        return 2 * stage_num(port_num);
    endfunction

endpackage
`default_nettype wire

// File: rtl/benes_cfg_bank.sv
`default_nettype none
// ============================================================================
//  Module   : benes_cfg_bank
//  Brief    : Shadow and active switch-setting arrays for one Benes network.
//             A row is written into the shadow by stage index; commit copies
//             the whole shadow to the active array in one edge.
//  Revision : 1.0 - initial release
// ============================================================================
module benes_cfg_bank
    import benes_select_loader_pkg::*;
#(
    parameter int STAGE_NUM  = 9,
    parameter int SWITCH_NUM = 16,
    localparam int STG_W     = (STAGE_NUM > 1) ? $clog2(STAGE_NUM) : 1
) (
    input  logic                                    CLK,
    input  logic                                    RST_N,
    input  logic                                    wr_en_i,
    input  logic [STG_W-1:0]                        wr_stage_i,
    input  logic [SWITCH_NUM-1:0]                   wr_data_i,
    input  logic                                    commit_i,
    output logic [0:STAGE_NUM-1][0:SWITCH_NUM-1]    active_o
);

    logic [0:STAGE_NUM-1][0:SWITCH_NUM-1] shadow_q;
    logic [0:STAGE_NUM-1][0:SWITCH_NUM-1] active_q;
    logic [0:SWITCH_NUM-1]                wr_row;

    // Input bit j is switch j; the select row is ascending, so remap per bit
    always_comb begin
        wr_row = '0;
        for (int j = 0; j < SWITCH_NUM; j++) begin
            wr_row[j] = wr_data_i[j];
        end
    end

    // Shadow row write and atomic shadow-to-active copy
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            if (wr_en_i) begin
                shadow_q[wr_stage_i] <= wr_row;
            end
            if (commit_i) begin
                active_q <= shadow_q;
            end
        end
    end

    assign active_o = active_q;

endmodule
`default_nettype wire

// File: rtl/benes_select_loader.sv
`default_nettype none
// ============================================================================
//  Module   : benes_select_loader
//  Brief    : Streams switch-setting rows into shadow configurations for the
//             RAM->module and module->RAM Benes networks and commits both to
//             the registered select outputs atomically on request.
//             Optional build macro BENES_CFG_PARITY_EN adds I_CFG_PARITY and
//             an even-parity check on each accepted beat.
//  Revision : 1.0 - initial release
// ============================================================================
module benes_select_loader
    import benes_select_loader_pkg::*;
#(
    parameter int PORT_NUM    = 32,
    parameter int EPOCH_W     = 8,
    localparam int SWITCH_NUM = PORT_NUM / 2,
    localparam int STAGE_NUM  = stage_num(PORT_NUM),
    localparam int BEAT_NUM   = beat_num(PORT_NUM)
) (
    input  logic                                    CLK,
    input  logic                                    RST_N,
    input  logic                                    I_CFG_VALID,
    output logic                                    O_CFG_READY,
    input  logic [SWITCH_NUM-1:0]                   I_CFG_DATA,
    input  logic                                    I_CFG_LAST,
`ifdef BENES_CFG_PARITY_EN
    input  logic                                    I_CFG_PARITY,
`endif
    input  logic                                    I_COMMIT,
    input  logic                                    I_CLEAR,
    output logic [0:STAGE_NUM-1][0:SWITCH_NUM-1]    O_MODULE_SELECT,
    output logic [0:STAGE_NUM-1][0:SWITCH_NUM-1]    O_SLOT_SELECT,
    output logic                                    O_ARMED,
    output logic                                    O_COMMIT_DONE,
    output logic [EPOCH_W-1:0]                      O_EPOCH,
    output logic                                    O_ERR,
    output logic [1:0]                              O_ERR_CODE
);

    localparam int K_W   = $clog2(BEAT_NUM);
    localparam int STG_W = (STAGE_NUM > 1) ? $clog2(STAGE_NUM) : 1;

    state_e              state_q, state_d;
    logic [K_W-1:0]      k_q, k_d;
    logic                err_q, err_d;
    err_code_e           code_q, code_d;
    logic [EPOCH_W-1:0]  epoch_q;
    logic                commit_done_q;

    logic                accept;
    logic                par_err;
    logic                last_beat;
    logic                wr_ok;
    logic                commit;
    logic                wr_module;
    logic                wr_slot;
    logic [STG_W-1:0]    module_stage;
    logic [STG_W-1:0]    slot_stage;

    // Ready/armed decode only registered state, so no input reaches an output
    assign O_CFG_READY = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    assign accept      = I_CFG_VALID && O_CFG_READY && !I_CLEAR;
    assign last_beat   = (k_q == K_W'(BEAT_NUM - 1));

`ifdef BENES_CFG_PARITY_EN
    assign par_err = (^I_CFG_DATA) != I_CFG_PARITY;
`else
    assign par_err = 1'b0;
`endif

    // Next-state, beat counter and error decode; clear overrides everything
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        err_d   = err_q;
        code_d  = code_q;
        wr_ok   = 1'b0;
        commit  = 1'b0;
        if (I_CLEAR) begin
            state_d = ST_IDLE;
            k_d     = '0;
            err_d   = 1'b0;
            code_d  = ERR_NONE;
        end else begin
            case (state_q)
                ST_IDLE, ST_LOAD: begin
                    if (accept) begin
                        if (par_err) begin
                            state_d = ST_ERROR;
                            err_d   = 1'b1;
                            code_d  = ERR_PARITY;
                        end else if (I_CFG_LAST && !last_beat) begin
                            state_d = ST_ERROR;
                            err_d   = 1'b1;
                            code_d  = ERR_EARLY_LAST;
                        end else if (!I_CFG_LAST && last_beat) begin
                            state_d = ST_ERROR;
                            err_d   = 1'b1;
                            code_d  = ERR_NO_LAST;
                        end else if (last_beat) begin
                            state_d = ST_ARMED;
                            k_d     = '0;
                            wr_ok   = 1'b1;
                        end else begin
                            state_d = ST_LOAD;
                            k_d     = k_q + K_W'(1);
                            wr_ok   = 1'b1;
                        end
                    end
                end
                ST_ARMED: begin
                    if (I_COMMIT) begin
                        state_d = ST_IDLE;
                        commit  = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_ERROR;
                end
            endcase
        end
    end

    // Control state, commit pulse and epoch registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= ST_IDLE;
            k_q           <= '0;
            err_q         <= 1'b0;
            code_q        <= ERR_NONE;
            epoch_q       <= '0;
            commit_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            err_q         <= err_d;
            code_q        <= code_d;
            commit_done_q <= commit;
            if (commit) begin
                epoch_q <= epoch_q + EPOCH_W'(1);
            end
        end
    end

    // First STAGE_NUM beats fill the module network, the rest the slot network
    assign wr_module    = wr_ok && (k_q < K_W'(STAGE_NUM));
    assign wr_slot      = wr_ok && (k_q >= K_W'(STAGE_NUM));
    assign module_stage = STG_W'(k_q);
    assign slot_stage   = STG_W'(k_q - K_W'(STAGE_NUM));

    benes_cfg_bank #(
        .STAGE_NUM  (STAGE_NUM),
        .SWITCH_NUM (SWITCH_NUM)
    ) u_module_bank (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .wr_en_i    (wr_module),
        .wr_stage_i (module_stage),
        .wr_data_i  (I_CFG_DATA),
        .commit_i   (commit),
        .active_o   (O_MODULE_SELECT)
    );

    benes_cfg_bank #(
        .STAGE_NUM  (STAGE_NUM),
        .SWITCH_NUM (SWITCH_NUM)
    ) u_slot_bank (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .wr_en_i    (wr_slot),
        .wr_stage_i (slot_stage),
        .wr_data_i  (I_CFG_DATA),
        .commit_i   (commit),
        .active_o   (O_SLOT_SELECT)
    );

    assign O_ARMED       = (state_q == ST_ARMED);
    assign O_COMMIT_DONE = commit_done_q;
    assign O_EPOCH       = epoch_q;
    assign O_ERR         = err_q;
    assign O_ERR_CODE    = code_q;

endmodule
`default_nettype wire

// File: tb/tb_benes_select_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_benes_select_loader
//  Brief    : Directed self-checking bench for benes_select_loader (32 ports).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_benes_select_loader;

    localparam int SW  = 16;
    localparam int STG = 9;
    localparam int BT  = 18;

    typedef logic [0:STG-1][0:SW-1] sel_t;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic         cfg_valid = 1'b0;
    logic         cfg_ready;
    logic [SW-1:0] cfg_data = '0;
    logic         cfg_last = 1'b0;
    logic         cfg_parity = 1'b0;
    logic         commit = 1'b0;
    logic         clear = 1'b0;
    sel_t         mod_sel;
    sel_t         slot_sel;
    logic         armed;
    logic         commit_done;
    logic [7:0]   epoch;
    logic         err;
    logic [1:0]   err_code;

    int n_vec = 0;
    int n_err = 0;

    sel_t exp_mod;
    sel_t exp_slot;

    always #5 CLK = ~CLK;

    benes_select_loader #(
        .PORT_NUM (32),
        .EPOCH_W  (8)
    ) dut (
        .CLK             (CLK),
        .RST_N           (RST_N),
        .I_CFG_VALID     (cfg_valid),
        .O_CFG_READY     (cfg_ready),
        .I_CFG_DATA      (cfg_data),
        .I_CFG_LAST      (cfg_last),
`ifdef BENES_CFG_PARITY_EN
        .I_CFG_PARITY    (cfg_parity),
`endif
        .I_COMMIT        (commit),
        .I_CLEAR         (clear),
        .O_MODULE_SELECT (mod_sel),
        .O_SLOT_SELECT   (slot_sel),
        .O_ARMED         (armed),
        .O_COMMIT_DONE   (commit_done),
        .O_EPOCH         (epoch),
        .O_ERR           (err),
        .O_ERR_CODE      (err_code)
    );

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Beat k of a configuration: byte k replicated, xor seed
    function automatic logic [SW-1:0] beat_word(input logic [15:0] seed, input int k);
        logic [7:0] b;
        b = 8'(k);
        return {b, b} ^ seed;
    endfunction

    // Expected select array: row s bit j = switch j of stage s
    function automatic sel_t build_sel(input logic [15:0] seed, input int base);
        sel_t r;
        logic [SW-1:0] w;
        r = '0;
        for (int s = 0; s < STG; s++) begin
            w = beat_word(seed, base + s);
            for (int j = 0; j < SW; j++) r[s][j] = w[j];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_beat(input logic [SW-1:0] d, input logic last, input logic bad_par);
        cfg_valid  = 1'b1;
        cfg_data   = d;
        cfg_last   = last;
        cfg_parity = (^d) ^ bad_par;
        tick();
        cfg_valid  = 1'b0;
        cfg_last   = 1'b0;
    endtask

    task automatic load_cfg(input logic [15:0] seed);
        for (int k = 0; k < BT; k++) send_beat(beat_word(seed, k), (k == BT - 1), 1'b0);
    endtask

    task automatic do_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_ready", 160'(cfg_ready), 160'(1));
        check("rst_armed", 160'(armed), 160'(0));
        check("rst_done", 160'(commit_done), 160'(0));
        check("rst_epoch", 160'(epoch), 160'(0));
        check("rst_err", 160'(err), 160'(0));
        check("rst_code", 160'(err_code), 160'(0));
        check("rst_mod", 160'(mod_sel), 160'(0));
        check("rst_slot", 160'(slot_sel), 160'(0));
        RST_N = 1'b1;
        tick();

        // Full load of configuration A then commit
        send_beat(beat_word(16'h0000, 0), 1'b0, 1'b0);
        check("load_ready", 160'(cfg_ready), 160'(1));
        check("load_armed", 160'(armed), 160'(0));
        for (int k = 1; k < BT; k++) send_beat(beat_word(16'h0000, k), (k == BT - 1), 1'b0);
        check("armed", 160'(armed), 160'(1));
        check("armed_ready", 160'(cfg_ready), 160'(0));
        check("pre_commit_mod", 160'(mod_sel), 160'(0));
        tick();
        check("armed_hold", 160'(armed), 160'(1));
        do_commit();
        exp_mod  = build_sel(16'h0000, 0);
        exp_slot = build_sel(16'h0000, STG);
        check("commit_done", 160'(commit_done), 160'(1));
        check("commit_epoch", 160'(epoch), 160'(1));
        check("commit_mod", 160'(mod_sel), 160'(exp_mod));
        check("commit_slot", 160'(slot_sel), 160'(exp_slot));
        check("commit_ready", 160'(cfg_ready), 160'(1));
        check("commit_armed", 160'(armed), 160'(0));
        tick();
        check("done_pulse", 160'(commit_done), 160'(0));

        // Early LAST on beat 5
        for (int k = 0; k < 5; k++) send_beat(beat_word(16'hFFFF, k), 1'b0, 1'b0);
        send_beat(beat_word(16'hFFFF, 5), 1'b1, 1'b0);
        check("early_err", 160'(err), 160'(1));
        check("early_code", 160'(err_code), 160'(1));
        check("early_ready", 160'(cfg_ready), 160'(0));
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_ready", 160'(cfg_ready), 160'(1));
        check("clr_err", 160'(err), 160'(0));
        check("clr_code", 160'(err_code), 160'(0));
        check("clr_mod", 160'(mod_sel), 160'(exp_mod));
        check("clr_slot", 160'(slot_sel), 160'(exp_slot));

        // LAST on the first beat
        send_beat(beat_word(16'h1234, 0), 1'b1, 1'b0);
        check("first_last_code", 160'(err_code), 160'(1));
        clear = 1'b1;
        tick();
        clear = 1'b0;

        // Missing LAST on beat 17; commit must be ignored
        for (int k = 0; k < BT; k++) send_beat(beat_word(16'hFFFF, k), 1'b0, 1'b0);
        check("nolast_err", 160'(err), 160'(1));
        check("nolast_code", 160'(err_code), 160'(2));
        do_commit();
        check("nolast_epoch", 160'(epoch), 160'(1));
        check("nolast_done", 160'(commit_done), 160'(0));
        check("nolast_mod", 160'(mod_sel), 160'(exp_mod));
        clear = 1'b1;
        tick();
        clear = 1'b0;

        // Clear and commit together in ARMED: clear wins
        load_cfg(16'hFFFF);
        check("cc_armed", 160'(armed), 160'(1));
        clear  = 1'b1;
        commit = 1'b1;
        tick();
        clear  = 1'b0;
        commit = 1'b0;
        check("cc_armed_after", 160'(armed), 160'(0));
        check("cc_ready", 160'(cfg_ready), 160'(1));
        check("cc_epoch", 160'(epoch), 160'(1));
        check("cc_done", 160'(commit_done), 160'(0));
        check("cc_mod", 160'(mod_sel), 160'(exp_mod));
        check("cc_slot", 160'(slot_sel), 160'(exp_slot));

        // 255 more commits: epoch passes 255 and wraps to 0
        for (int i = 0; i < 255; i++) begin
            if (i == 254) check("epoch_255", 160'(epoch), 160'(255));
            load_cfg(16'(i * 37 + 1));
            do_commit();
        end
        exp_mod  = build_sel(16'(254 * 37 + 1), 0);
        exp_slot = build_sel(16'(254 * 37 + 1), STG);
        check("wrap_epoch", 160'(epoch), 160'(0));
        check("wrap_done", 160'(commit_done), 160'(1));
        check("wrap_mod", 160'(mod_sel), 160'(exp_mod));
        check("wrap_slot", 160'(slot_sel), 160'(exp_slot));

`ifdef BENES_CFG_PARITY_EN
        // Bad parity on beat 3
        tick();
        for (int k = 0; k < 3; k++) send_beat(beat_word(16'h5A5A, k), 1'b0, 1'b0);
        send_beat(beat_word(16'h5A5A, 3), 1'b0, 1'b1);
        check("par_err", 160'(err), 160'(1));
        check("par_code", 160'(err_code), 160'(3));
        check("par_mod", 160'(mod_sel), 160'(exp_mod));
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("par_clr", 160'(err_code), 160'(0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/benes_select_loader.md
# benes_select_loader

Configuration front-end for the dual Benes interconnect: accepts switch-setting words over a valid/ready stream, assembles a complete shadow configuration for the RAM→module and module→RAM networks, and atomically commits it to registered select outputs on request. It sits between the host/sequencer and the interconnect's module-select and slot-select inputs, so a new permutation is loaded while the previous one is still routing traffic.

## Interface
- PORT_NUM, 32, ports per Benes network (power of two, ≥4)
- SWITCH_NUM, PORT_NUM/2, 2×2 switches per stage
- STAGE_NUM, 2*$clog2(PORT_NUM)-1, switch stages per network
- BEAT_NUM, 2*STAGE_NUM, beats per full configuration
- EPOCH_W, 8, commit-counter width

- CLK  input  1  clock
- RST_N  input  1  reset, asynchronous, active-low
- I_CFG_VALID  input  1  beat valid
- O_CFG_READY  output  1  loader accepts beats
- I_CFG_DATA  input  SWITCH_NUM  one stage row, bit j = switch j (1 = cross)
- I_CFG_LAST  input  1  final beat of configuration
- I_CFG_PARITY  input  1  even parity over I_CFG_DATA (present only with BENES_CFG_PARITY_EN)
- I_COMMIT  input  1  request shadow→active transfer
- I_CLEAR  input  1  abort load / clear error
- O_MODULE_SELECT  output  [0:STAGE_NUM-1][0:SWITCH_NUM-1]  active RAM→module settings
- O_SLOT_SELECT  output  [0:STAGE_NUM-1][0:SWITCH_NUM-1]  active module→RAM settings
- O_ARMED  output  1  shadow complete, awaiting commit
- O_COMMIT_DONE  output  1  one-cycle pulse on commit
- O_EPOCH  output  EPOCH_W  commits since reset
- O_ERR  output  1  sticky error
- O_ERR_CODE  output  2  01 early LAST, 10 missing LAST, 11 parity

## Operation
- Beat accepted when I_CFG_VALID & O_CFG_READY & !I_CLEAR.
- Beat counter k (0..BEAT_NUM-1): k<STAGE_NUM writes module shadow stage k; else slot shadow stage k-STAGE_NUM.
- States: IDLE, LOAD, ARMED, ERROR. O_CFG_READY = 1 in IDLE/LOAD, 0 in ARMED/ERROR.
- IDLE → LOAD on first accepted beat (k=0 → 1); if that beat has LAST → ERROR code 01.
- LOAD: accepted beat with LAST and k<BEAT_NUM-1 → ERROR 01; k=BEAT_NUM-1 without LAST → ERROR 10; k=BEAT_NUM-1 with LAST → ARMED, k→0.
- ARMED: I_COMMIT → both active arrays ← shadows, O_COMMIT_DONE pulse, O_EPOCH+1 (wraps 2^EPOCH_W-1 → 0), → IDLE.
- I_COMMIT outside ARMED ignored; no pulse, no epoch change.
- I_CLEAR in any state: → IDLE, k→0, O_ERR/O_ERR_CODE → 0; shadows and actives unchanged. I_CLEAR and I_COMMIT together in ARMED: clear wins, no commit.
- Errored beat is not written to shadow; partially written shadow is never committed.
- Reset: state IDLE, k=0, shadows/actives 0 (all bar), O_CFG_READY=1, O_ARMED=0, O_COMMIT_DONE=0, O_EPOCH=0, O_ERR=0, O_ERR_CODE=00.

## Timing
- All outputs registered; no combinational input→output path.
- Beat accepted at edge N: O_CFG_READY/O_ARMED reflect new state after edge N; k=BEAT_NUM-1 beat → O_ARMED=1, O_CFG_READY=0 after edge N.
- I_COMMIT high at edge N in ARMED: O_MODULE_SELECT, O_SLOT_SELECT, O_EPOCH update after edge N; O_COMMIT_DONE high for cycle N..N+1 only; O_CFG_READY=1 after edge N.
- Minimum load-to-commit: BEAT_NUM back-to-back beats + 1 cycle.
- Both select outputs change on the same edge; never a mixed configuration.

## Configuration
- BENES_CFG_PARITY_EN defined: I_CFG_PARITY port exists; accepted beat with ^I_CFG_DATA ≠ I_CFG_PARITY → ERROR code 11, beat discarded; parity checked before LAST checks.
- Undefined: port absent, no parity check, code 11 never produced.

## Structure
- Shared package: state enum (IDLE/LOAD/ARMED/ERROR), error-code enum, STAGE_NUM/BEAT_NUM derivation function.
- One sub-module: benes_cfg_bank (shadow + active arrays for one network, stage-indexed write, commit copy), instantiated twice.

## Test plan
- Reset, PORT_NUM=32: 18 beats, stage k data = k replicated, LAST on beat 17, commit → selects match, O_EPOCH=1, O_COMMIT_DONE one cycle.
- LAST on beat 5 → O_ERR=1, code 01, O_CFG_READY=0; I_CLEAR → READY=1, actives unchanged.
- Beat 17 without LAST → code 10; I_COMMIT ignored, O_EPOCH unchanged.
- ARMED with I_CLEAR and I_COMMIT same cycle → no commit, IDLE, O_EPOCH unchanged.
- 256 commits → O_EPOCH wraps to 0; actives track last configuration.
- BENES_CFG_PARITY_EN: beat 3 with wrong parity → code 11, shadow stage 3 unchanged.
